// File: rtl/hazard_pkg.sv
// Shared encodings and shadow-entry type for the ID-resolved hazard controller.
// Optype encodings match the control unit's hazard_optype field.
package hazard_pkg;

    // Destination width carried by a shadow entry; the top's REG_AW must equal this.
    localparam int SHADOW_RD_W = 5;

    typedef enum logic [1:0] {
        OPT_NONE = 2'd0,
        OPT_ALU  = 2'd1,
        OPT_LOAD = 2'd2,
        OPT_LONG = 2'd3
    } opt_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_WB    = 2'd3
    } fwd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lat_state_e;

    typedef struct packed {
        logic                   v;
        logic [SHADOW_RD_W-1:0] rd;
        opt_e                   opt;
    } shadow_t;

    // x0 is hardwired, so it never creates a dependency.
    function automatic logic src_match(shadow_t e, logic [SHADOW_RD_W-1:0] rs, logic rs_use);
        return e.v && (e.rd == rs) && (rs != '0) && rs_use;
    endfunction

    // Youngest producer wins; a LOAD in EX cannot forward and is covered by the stall.
    function automatic fwd_e fwd_pick(logic m_ex, logic ex_alu, logic m_mem, logic m_wb);
        if (m_ex && ex_alu) return FWD_EXMEM;
        else if (m_mem)     return FWD_MEMWB;
        else if (m_wb)      return FWD_WB;
        else                return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline slot {v, rd, opt}: holds when frozen, loads an empty entry on bubble.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    hold,
    input  logic    bubble,
    input  shadow_t d,
    output shadow_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!hold) begin
            q <= bubble ? shadow_t'('0) : d;
        end
    end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB destinations, load-use stall,
// branch flush, forwarding selects and a long-op hold FSM with a sticky watchdog.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | pipeline flowing; load-use stall and branch flush allowed
// ST_BUSY | long op sitting in EX; everything frozen until mdu_done
module hazard_ctrl_pipe
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int OPT_W   = 2,
    parameter int MAX_LAT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1use,
    input  logic              id_rs2use,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic [OPT_W-1:0]  id_optype,
    input  logic              branch_taken,
    input  logic              mdu_done,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic              hold_back,
    output logic [1:0]        fwd_rs1,
    output logic [1:0]        fwd_rs2,
    output logic              wd_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LAT);

    lat_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wd_q, wd_d;

    shadow_t id_entry, ex_q, ex_eff, mem_q, wb_q;
    logic    busy, done_now, held, lu_stall, id_long;
    logic    m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;

    // The LONG optype is kept even for non-writing ops so the FSM still sees it in EX.
    always_comb begin
        id_entry     = '0;
        id_entry.v   = id_valid & id_regwrite & (id_rd != '0);
        id_entry.rd  = id_rd;
        id_entry.opt = id_valid ? opt_e'(id_optype) : OPT_NONE;
    end

    assign busy     = (state_q == ST_BUSY);
    assign done_now = busy & mdu_done;
    assign held     = busy & ~mdu_done;
    assign id_long  = id_valid & (opt_e'(id_optype) == OPT_LONG);

    // On mdu_done the long result is ready in EX, so it forwards and travels on as an ALU result.
    always_comb begin
        ex_eff = ex_q;
        if (done_now) ex_eff.opt = OPT_ALU;
    end

    assign m_ex1  = src_match(ex_eff, id_rs1, id_rs1use);
    assign m_ex2  = src_match(ex_eff, id_rs2, id_rs2use);
    assign m_mem1 = src_match(mem_q,  id_rs1, id_rs1use);
    assign m_mem2 = src_match(mem_q,  id_rs2, id_rs2use);
    assign m_wb1  = src_match(wb_q,   id_rs1, id_rs1use);
    assign m_wb2  = src_match(wb_q,   id_rs2, id_rs2use);

    assign lu_stall = ~held & (ex_eff.opt == OPT_LOAD) & (m_ex1 | m_ex2);

    hazard_shadow_stage u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (held),
        .bubble (lu_stall),
        .d      (id_entry),
        .q      (ex_q)
    );

    hazard_shadow_stage u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (held),
        .bubble (1'b0),
        .d      (ex_eff),
        .q      (mem_q)
    );

    hazard_shadow_stage u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (held),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        hold_back   = 1'b0;
        flush_ifid  = 1'b0;
        fwd_rs1     = FWD_RF;
        fwd_rs2     = FWD_RF;

        case (state_q)
            ST_IDLE: begin
                if (id_long && !lu_stall) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (mdu_done) begin
                    // A LONG op already waiting in ID enters EX on this edge and holds again.
                    state_d = (id_long && !lu_stall) ? ST_BUSY : ST_IDLE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        hold_back   = held;
        stall_pc    = held | lu_stall;
        stall_ifid  = held | lu_stall;
        bubble_idex = lu_stall;
        flush_ifid  = branch_taken & id_valid & ~lu_stall & ~busy;
        fwd_rs1     = fwd_pick(m_ex1, ex_eff.opt == OPT_ALU, m_mem1, m_wb1);
        fwd_rs2     = fwd_pick(m_ex2, ex_eff.opt == OPT_ALU, m_mem2, m_wb2);
    end

    assign wd_d   = wd_q | (cnt_d == CNT_MAX);
    assign wd_err = wd_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: forwarding, load-use, x0, long-op hold and watchdog.
module tb_hazard_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs1use, id_rs2use, id_regwrite;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_optype;
    logic       branch_taken, mdu_done;
    logic       stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_back, wd_err;
    logic [1:0] fwd_rs1, fwd_rs2;
    logic [9:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cnt;

    localparam logic [1:0] NONE = 2'd0, ALU = 2'd1, LOAD = 2'd2, LONG = 2'd3;

    hazard_ctrl_pipe #(.REG_AW(5), .OPT_W(2), .MAX_LAT(64), .CNT_W(7)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rs1use    (id_rs1use),
        .id_rs2use    (id_rs2use),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_optype    (id_optype),
        .branch_taken (branch_taken),
        .mdu_done     (mdu_done),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .hold_back    (hold_back),
        .fwd_rs1      (fwd_rs1),
        .fwd_rs2      (fwd_rs2),
        .wd_err       (wd_err)
    );

    always #5 clk = ~clk;

    assign outs = {stall_pc, stall_ifid, flush_ifid, bubble_idex, hold_back, fwd_rs1, fwd_rs2, wd_err};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic [1:0] opt);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1use   = u1;
        id_rs2      = rs2;
        id_rs2use   = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_optype   = opt;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, NONE);
    endtask

    initial begin
        rst_n        = 1'b0;
        branch_taken = 1'b0;
        mdu_done     = 1'b0;
        nop();
        #11;
        check("reset_outs", 32'(outs), 32'h0);
        rst_n = 1'b1;

        // ALU back-to-back: add x5, then consumers one and two behind
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, ALU);
        check("alu_first_fwd", 32'(fwd_rs1), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, ALU);
        check("alu_fwd_exmem", 32'(fwd_rs1), 32'd1);
        check("alu_no_stall", 32'(stall_pc), 32'd0);
        check("alu_rs2_rf", 32'(fwd_rs2), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, ALU);
        check("alu_fwd_memwb", 32'(fwd_rs1), 32'd2);
        tick();
        set_id(1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, ALU);
        check("alu_fwd_wb", 32'(fwd_rs1), 32'd3);
        check("alu_rs2_memwb", 32'(fwd_rs2), 32'd2);
        tick();
        nop(); tick(); tick(); tick();

        // Load-use with a coinciding branch: stall wins, flush follows next cycle
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, LOAD);
        check("lw_no_stall", 32'(stall_pc), 32'd0);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 5'd11, 1'b1, ALU);
        branch_taken = 1'b1;
        #1;
        check("lu_stall_vec", 32'({stall_pc, stall_ifid, bubble_idex, hold_back}), 32'b1110);
        check("lu_flush_blocked", 32'(flush_ifid), 32'd0);
        tick();
        check("lu_stall_released", 32'({stall_pc, stall_ifid, bubble_idex}), 32'b000);
        check("lu_fwd_memwb", 32'(fwd_rs2), 32'd2);
        check("lu_flush_next", 32'(flush_ifid), 32'd1);
        tick();
        branch_taken = 1'b0;
        nop(); tick(); tick(); tick();

        // x0 never matches; an unused source never forwards or stalls
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, LOAD);
        tick();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 1'b1, ALU);
        check("x0_no_stall", 32'(stall_pc), 32'd0);
        check("x0_fwd", 32'({fwd_rs1, fwd_rs2}), 32'd0);
        tick();
        set_id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, LOAD);
        tick();
        set_id(1'b1, 5'd1, 1'b1, 5'd12, 1'b0, 5'd15, 1'b1, ALU);
        check("unused_no_stall", 32'(stall_pc), 32'd0);
        check("unused_fwd_rs2", 32'(fwd_rs2), 32'd0);
        tick();
        nop(); tick(); tick(); tick();

        // Long op to x7, done after five held cycles
        set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, LONG);
        check("long_idle_hold", 32'(hold_back), 32'd0);
        tick();
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, ALU);
        hold_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 2);
            #1;
            if (hold_back && stall_pc && stall_ifid && !bubble_idex) hold_cnt++;
            if (i == 2) check("busy_no_flush", 32'(flush_ifid), 32'd0);
            tick();
        end
        branch_taken = 1'b0;
        check("long_hold_cycles", 32'(hold_cnt), 32'd5);
        mdu_done = 1'b1;
        #1;
        check("done_hold_low", 32'({hold_back, stall_pc}), 32'b00);
        check("done_fwd_exmem", 32'(fwd_rs1), 32'd1);
        tick();
        mdu_done = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, ALU);
        check("after_long_fwd_memwb", 32'(fwd_rs1), 32'd2);
        check("after_long_no_hold", 32'(hold_back), 32'd0);
        nop();
        mdu_done = 1'b1;
        #1;
        check("idle_done_ignored", 32'(hold_back), 32'd0);
        tick();
        mdu_done = 1'b0;
        #1;
        check("idle_done_stays_idle", 32'(hold_back), 32'd0);
        tick(); tick(); tick();

        // Watchdog: non-writing LONG with no completion
        set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, LONG);
        tick();
        nop();
        check("wd_busy_entered", 32'(hold_back), 32'd1);
        for (int i = 0; i < 63; i++) tick();
        check("wd_before_limit", 32'(wd_err), 32'd0);
        tick();
        check("wd_at_limit", 32'(wd_err), 32'd1);
        tick(); tick(); tick();
        check("wd_sticky_busy", 32'({wd_err, hold_back}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 32'(outs), 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", 32'({hold_back, wd_err}), 32'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_pipe.md
Name: hazard_ctrl_pipe

Overview:
- Stateful hazard controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). Branches resolve in ID.
- Consumes the decoded rs1use/rs2use, RegWrite, rd and hazard_optype of the ID-stage instruction.
- Keeps a shadow pipeline of in-flight destinations in EX/MEM/WB.
- Produces stall, flush and forwarding selects.
- Adds a variable-latency (multiply/divide) hold FSM with a watchdog.

Parameters:
- REG_AW, 5, register address width.
- OPT_W, 2, hazard_optype width.
- MAX_LAT, 64, watchdog limit in cycles for a long op.
- CNT_W, 7, watchdog counter width; must hold MAX_LAT.

Ports:
- clk in 1: core clock.
- rst_n in 1: asynchronous active-low reset.
- id_valid in 1: ID holds a real instruction.
- id_rs1 in REG_AW: ID source register 1.
- id_rs2 in REG_AW: ID source register 2.
- id_rs1use in 1: rs1 is read by the ID instruction.
- id_rs2use in 1: rs2 is read by the ID instruction.
- id_rd in REG_AW: ID destination register.
- id_regwrite in 1: ID instruction writes rd.
- id_optype in OPT_W: 0 NONE, 1 ALU, 2 LOAD, 3 LONG.
- branch_taken in 1: ID branch/jump redirects PC.
- mdu_done in 1: one-cycle pulse, long-op result valid.
- stall_pc out 1: hold PC.
- stall_ifid out 1: hold IF/ID.
- flush_ifid out 1: clear IF/ID.
- bubble_idex out 1: load a NOP into ID/EX.
- hold_back out 1: freeze ID/EX, EX/MEM, MEM/WB.
- fwd_rs1 out 2: rs1 forward select.
- fwd_rs2 out 2: rs2 forward select.
- wd_err out 1: sticky watchdog error.

Behaviour:
- Shadow entries ex, mem, wb each hold {v, rd, opt}.
  - An entry is written only if id_valid & id_regwrite & id_rd!=0.
  - Otherwise v=0.
- Reset (async, rst_n=0):
  - All shadow v=0, FSM=IDLE, counter=0, wd_err=0.
  - All outputs 0.
- Match rule:
  - match_X(rs) = X.v & X.rd==rs & rs!=0 & use bit.
  - x0 never matches.
- Load-use:
  - ex.opt==LOAD and match_ex on either used source → lu_stall=1.
  - lu_stall drives stall_pc=stall_ifid=bubble_idex=1 for exactly one cycle.
  - Shadow shifts with ex<=bubble (v=0).
- Forward select, evaluated combinationally on ID operands and captured into ID/EX by the datapath. Youngest wins:
  - match_ex & ex.opt==ALU → 01 (EX/MEM).
  - else match_mem → 10 (MEM/WB).
  - else match_wb → 11 (WB write data).
  - else 00 (regfile).
  - During lu_stall the selects are don't-care.
- Flush:
  - flush_ifid = branch_taken & id_valid & !lu_stall & FSM==IDLE.
  - If a stall and branch_taken coincide, the stall wins and the branch is re-evaluated next cycle.
- Long-op FSM: states IDLE, BUSY.
  - IDLE→BUSY on the cycle a LONG instruction enters ex (ex.opt==LONG & ex.v, or v=0 with rd=0 write).
  - The ex entry carries opt=LONG whether or not it writes.
  - In BUSY:
    - hold_back=stall_pc=stall_ifid=1, bubble_idex=0.
    - Shadow frozen.
    - Counter increments each cycle.
  - BUSY→IDLE on mdu_done:
    - Shadow resumes the same cycle; ex.opt is rewritten to ALU so younger consumers forward 01.
    - Counter cleared.
  - Counter reaching MAX_LAT sets wd_err (sticky until reset). The FSM stays BUSY.
  - mdu_done while IDLE is ignored.
- Priority: BUSY hold > load-use stall > branch flush.
- Normal shift when not held: wb<=mem, mem<=ex, ex<=ID entry (bubble if lu_stall).
- Latency:
  - Stall decisions are combinational on the current shadow state.
  - The shadow updates on the rising edge of clk.

Decomposition:
- Shared package hazard_pkg holds:
  - OPT_NONE/ALU/LOAD/LONG encodings.
  - FWD_RF/EXMEM/MEMWB/WB encodings.
  - The shadow-entry struct.
- The same optype encodings are used by the control unit's hazard_optype.
- One sub-module, hazard_shadow_stage, holds a single {v, rd, opt} register with hold/bubble controls; it is instantiated three times.
- FSM, watchdog and match logic stay in the top module.

Test Plan:
- ALU back-to-back: add x5 (ALU) then add using rs1=x5 → fwd_rs1=01, no stall. One cycle later, with the consumer two behind → fwd_rs1=10.
- Load-use: lw x6 then add rs2=x6 → one cycle of stall_pc=stall_ifid=bubble_idex=1, then fwd_rs2=10 next cycle, no second stall.
- x0 and unused source: lw x0 then add rs1=x0 → no stall. rs2use=0 with id_rs2 matching → fwd_rs2=00.
- Long op: LONG to x7, mdu_done after 5 cycles → hold_back high exactly 5 cycles. The consumer of x7 then sees fwd=01.
- Watchdog: LONG with no mdu_done → wd_err rises at cycle MAX_LAT (64) and stays high. An rst_n pulse mid-BUSY clears all outputs asynchronously.
- Branch vs stall: branch_taken coinciding with load-use → flush_ifid=0 that cycle, =1 the next cycle.
